mdio_responder: RTL and testbench

- Clause-22 MDIO management responder (PHY-side slave) that answers the MAC's MDIO master on the mdc/mdio_in/mdio_out/mdio_oen interface.
- Used as an on-chip management target and as a PHY stand-in for simulation and bring-up.
- Holds a small 16-bit register file, serves reads and writes addressed to its PHY address, and reports completed writes to local logic.

---
 rtl/mdio_pkg.sv | 25 ++
 rtl/mdio_responder_if.sv | 30 +++
 rtl/mdio_sync_edge.sv | 34 +++
 rtl/mdio_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_mdio_responder.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause-22 MDIO responder.
package mdio_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ST,
    OP,
    PHYAD,
    REGAD,
    TA,
    DATA_RD,
    DATA_WR,
    SKIP
  } state_t;

  localparam logic [1:0] OP_READ      = 2'b10;
  localparam logic [1:0] OP_WRITE     = 2'b01;
  localparam logic [4:0] REGAD_STATUS = 5'd1;

  localparam int PHYAD_W    = 5;
  localparam int DATA_W     = 16;
  // Bits left in a frame once PHYAD has been received: REGAD + TA + data.
  localparam int FRAME_TAIL = 23;

endpackage

// File: rtl/mdio_responder_if.sv
// MDIO line plus local write-report signals of the responder.
// Handshake: there is no valid/ready pair. wr_strobe is a one-cycle
// qualifier for wr_regad/wr_data (which then hold until the next write);
// frame_err is a one-cycle event; state is the live FSM state for debug.
interface mdio_responder_if;
  import mdio_pkg::*;

  logic        mdc;
  logic        mdio_in;
  logic        mdio_out;
  logic        mdio_oen;
  logic [4:0]  phy_addr;
  logic [15:0] status_in;
  logic        wr_strobe;
  logic [4:0]  wr_regad;
  logic [15:0] wr_data;
  logic        frame_err;
  state_t      state;

  modport slave (
    input  mdc, mdio_in, phy_addr, status_in,
    output mdio_out, mdio_oen, wr_strobe, wr_regad, wr_data, frame_err, state
  );

  modport master (
    output mdc, mdio_in, phy_addr, status_in,
    input  mdio_out, mdio_oen, wr_strobe, wr_regad, wr_data, frame_err, state
  );

endinterface

// File: rtl/mdio_sync_edge.sv
// Brings mdc and mdio_in into the clk_clk domain and flags mdc rising edges.
module mdio_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic mdc,
  input  logic mdio_in,
  output logic rise,
  output logic mdio_sync
);

  logic mdc_s1, mdc_s2, mdc_s3;
  logic mdio_s1, mdio_s2;

  // Two-flop synchronisers, plus one extra mdc stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdc_s1  <= 1'b0;
      mdc_s2  <= 1'b0;
      mdc_s3  <= 1'b0;
      mdio_s1 <= 1'b1;
      mdio_s2 <= 1'b1;
    end else begin
      mdc_s1  <= mdc;
      mdc_s2  <= mdc_s1;
      mdc_s3  <= mdc_s2;
      mdio_s1 <= mdio_in;
      mdio_s2 <= mdio_s1;
    end
  end

  assign rise      = mdc_s2 & ~mdc_s3;
  assign mdio_sync = mdio_s2;

endmodule

// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder (PHY side) with a small 16-bit register file.
// Optional build macro MDIO_PREAMBLE_SUPPRESS_EN: accept a start after a
// single idle 1, and force bit 6 (preamble suppression) in REGAD 1 reads.
module mdio_responder
  import mdio_pkg::*;
#(
  parameter int          NUM_REGS      = 8,
  parameter int          PREAMBLE_BITS = 32,
  parameter logic [15:0] RESET_REG0    = 16'h1140
) (
  input logic        clk_clk,
  input logic        reset_reset,
  mdio_responder_if.slave bus
);

  localparam int PW = $clog2(PREAMBLE_BITS + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(PREAMBLE_BITS);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam logic [PW-1:0] PRE_REQ = PW'(1);
`else
  localparam logic [PW-1:0] PRE_REQ = PRE_MAX;
`endif

  logic rise;
  logic sbit;

  mdio_sync_edge u_sync (
    .clk       (clk_clk),
    .rst       (reset_reset),
    .mdc       (bus.mdc),
    .mdio_in   (bus.mdio_in),
    .rise      (rise),
    .mdio_sync (sbit)
  );

  state_t        state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    op_q;
  logic [4:0]    phyad_q;
  logic [4:0]    regad_q;
  logic [15:0]   shift_q;
  logic          oen_q, oen_d;
  logic          out_q, out_d;
  logic          err_d, wr_done, load_rd, shift_rd;
  logic [15:0]   regs [NUM_REGS];
  logic [15:0]   rd_val;
  logic [1:0]    op_nx;
  logic [4:0]    phyad_nx;
  logic [4:0]    regad_nx;
  logic [15:0]   wr_val;

  assign op_nx    = {op_q[0], sbit};
  assign phyad_nx = {phyad_q[3:0], sbit};
  assign regad_nx = {regad_q[3:0], sbit};
  assign wr_val   = {shift_q[14:0], sbit};

  // Read source selected by the REGAD value completing this cycle.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (regad_nx == i[4:0]) rd_val = regs[i];
    end
    if (regad_nx == REGAD_STATUS) begin
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
      rd_val = bus.status_in | 16'h0040;
`else
      rd_val = bus.status_in;
`endif
    end
  end

  // FSM state register.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // Next-state and per-bit control; everything advances only on an mdc rise.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pre_d    = pre_q;
    oen_d    = oen_q;
    out_d    = out_q;
    err_d    = 1'b0;
    wr_done  = 1'b0;
    load_rd  = 1'b0;
    shift_rd = 1'b0;
    if (rise) begin
      case (state_q)
        IDLE: begin
          if (sbit) begin
            if (pre_q != PRE_MAX) pre_d = pre_q + 1'b1;
          end else begin
            pre_d = '0;
            if (pre_q >= PRE_REQ) state_d = ST;
          end
        end
        ST: begin
          if (sbit) begin
            state_d = OP;
            cnt_d   = '0;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        OP: begin
          if (cnt_q == 5'd0) begin
            cnt_d = 5'd1;
          end else begin
            cnt_d = '0;
            if (op_nx == OP_READ || op_nx == OP_WRITE) begin
              state_d = PHYAD;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
        end
        PHYAD: begin
          if (cnt_q == 5'(PHYAD_W - 1)) begin
            cnt_d   = '0;
            state_d = (phyad_nx == bus.phy_addr) ? REGAD : SKIP;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        REGAD: begin
          if (cnt_q == 5'd4) begin
            cnt_d   = '0;
            state_d = TA;
            load_rd = (op_q == OP_READ);
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        TA: begin
          if (op_q == OP_READ) begin
            // Master has just sampled TA bit 1: claim the line with a 0.
            oen_d   = 1'b0;
            out_d   = 1'b0;
            cnt_d   = '0;
            state_d = DATA_RD;
          end else if (cnt_q == 5'd1) begin
            cnt_d   = '0;
            state_d = DATA_WR;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        DATA_RD: begin
          if (cnt_q == 5'(DATA_W)) begin
            oen_d   = 1'b1;
            out_d   = 1'b1;
            state_d = IDLE;
          end else begin
            out_d    = shift_q[15];
            shift_rd = 1'b1;
            cnt_d    = cnt_q + 5'd1;
          end
        end
        DATA_WR: begin
          if (cnt_q == 5'(DATA_W - 1)) begin
            wr_done = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        SKIP: begin
          if (cnt_q == 5'(FRAME_TAIL - 1)) state_d = IDLE;
          else                             cnt_d   = cnt_q + 5'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath: counters, field shifters, line drive and write reporting.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      cnt_q         <= '0;
      pre_q         <= '0;
      op_q          <= '0;
      phyad_q       <= '0;
      regad_q       <= '0;
      shift_q       <= '0;
      oen_q         <= 1'b1;
      out_q         <= 1'b1;
      bus.wr_strobe <= 1'b0;
      bus.wr_regad  <= '0;
      bus.wr_data   <= '0;
      bus.frame_err <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      pre_q         <= pre_d;
      oen_q         <= oen_d;
      out_q         <= out_d;
      bus.wr_strobe <= wr_done;
      bus.frame_err <= err_d;
      if (rise && state_q == OP)    op_q    <= op_nx;
      if (rise && state_q == PHYAD) phyad_q <= phyad_nx;
      if (rise && state_q == REGAD) regad_q <= regad_nx;
      if (load_rd)                        shift_q <= rd_val;
      else if (shift_rd)                  shift_q <= {shift_q[14:0], 1'b0};
      else if (rise && state_q == DATA_WR) shift_q <= wr_val;
      if (wr_done) begin
        bus.wr_regad <= regad_q;
        bus.wr_data  <= wr_val;
      end
    end
  end

  // Register file; REGAD 1 is the live status input and never stored.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= (i == 0) ? RESET_REG0 : 16'h0000;
    end else if (wr_done) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (regad_q == i[4:0] && i != 1) regs[i] <= wr_val;
      end
    end
  end

  assign bus.mdio_out = out_q;
  assign bus.mdio_oen = oen_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench for mdio_responder: drives MDIO frames as a master and
// checks line drive, register contents, write reports and frame errors.
module tb_mdio_responder;
  import mdio_pkg::*;

  logic clk_clk;
  logic reset_reset;
  int   checks = 0;
  int   errors = 0;
  int   strobe_cnt = 0;
  int   err_cnt = 0;

  mdio_responder_if bus();

  mdio_responder dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .bus         (bus)
  );

  // Clock and reset.
  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  // Pulse monitors.
  always @(posedge clk_clk) begin
    if (!reset_reset && bus.wr_strobe) strobe_cnt++;
    if (!reset_reset && bus.frame_err) err_cnt++;
  end

  // One MDC bit: data set while mdc low, line sampled just before the rise.
  task automatic bit_cycle(input logic b, output logic so, output logic sout);
    bus.mdio_in = b;
    #80;
    so   = bus.mdio_oen;
    sout = bus.mdio_out;
    bus.mdc = 1'b1;
    #80;
    bus.mdc = 1'b0;
  endtask

  function automatic logic [31:0] build_frame(input logic [1:0] op, input logic [4:0] phyad,
                                              input logic [4:0] regad, input logic [15:0] wdata);
    if (op == OP_READ) return {2'b01, op, phyad, regad, 2'b11, 16'hFFFF};
    else               return {2'b01, op, phyad, regad, 2'b10, wdata};
  endfunction

  // Preamble, 32-bit frame, one trailing idle bit; collects read-side view.
  task automatic run_frame(input int pre_n, input logic [1:0] op, input logic [4:0] phyad,
                           input logic [4:0] regad, input logic [15:0] wdata,
                           output logic [15:0] rdata, output int low_cnt,
                           output logic ta1_oen, output logic [1:0] ta2);
    logic [31:0] fr;
    logic so, sout;
    fr = build_frame(op, phyad, regad, wdata);
    rdata = '0; low_cnt = 0; ta1_oen = 1'b0; ta2 = 2'b11;
    for (int i = 0; i < pre_n; i++) bit_cycle(1'b1, so, sout);
    for (int i = 31; i >= 0; i--) begin
      bit_cycle(fr[i], so, sout);
      if (!so) low_cnt++;
      if (i == 17) ta1_oen = so;
      if (i == 16) ta2 = {so, sout};
      if (i <= 15) rdata[i] = sout;
    end
    bit_cycle(1'b1, so, sout);
    if (!so) low_cnt++;
  endtask

  task automatic test_reset();
    reset_reset = 1'b1;
    bus.mdc = 1'b0; bus.mdio_in = 1'b1; bus.phy_addr = 5'h03; bus.status_in = 16'h0000;
    repeat (3) @(negedge clk_clk);
    checks++;
    if ({bus.mdio_oen, bus.mdio_out, bus.wr_strobe, bus.frame_err} !== 4'b1100) begin
      errors++; $display("FAIL reset_lines got %b want 1100", {bus.mdio_oen, bus.mdio_out, bus.wr_strobe, bus.frame_err});
    end
    checks++;
    if ({bus.wr_regad, bus.wr_data} !== 21'h0) begin
      errors++; $display("FAIL reset_wr got %h/%h want 00/0000", bus.wr_regad, bus.wr_data);
    end
    checks++;
    if (bus.state !== IDLE) begin
      errors++; $display("FAIL reset_state got %0d want IDLE", bus.state);
    end
    reset_reset = 1'b0;
    repeat (2) @(negedge clk_clk);
  endtask

  task automatic test_read_reg0(input string tag);
    logic [15:0] rd; int low; logic t1; logic [1:0] t2;
    run_frame(32, OP_READ, 5'h03, 5'd0, 16'h0, rd, low, t1, t2);
    checks++;
    if (rd !== 16'h1140) begin errors++; $display("FAIL %s_data got %h want 1140", tag, rd); end
    checks++;
    if (t1 !== 1'b1 || t2 !== 2'b00) begin errors++; $display("FAIL %s_ta got %b/%b want 1/00", tag, t1, t2); end
    checks++;
    if (low !== 17) begin errors++; $display("FAIL %s_oen_bits got %0d want 17", tag, low); end
  endtask

  task automatic test_write_read();
    logic [15:0] rd; int low; logic t1; logic [1:0] t2; int s0;
    s0 = strobe_cnt;
    run_frame(32, OP_WRITE, 5'h03, 5'd2, 16'hBEEF, rd, low, t1, t2);
    checks++;
    if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL wr_strobes got %0d want 1", strobe_cnt - s0); end
    checks++;
    if (bus.wr_regad !== 5'd2 || bus.wr_data !== 16'hBEEF) begin
      errors++; $display("FAIL wr_report got %h/%h want 02/beef", bus.wr_regad, bus.wr_data);
    end
    checks++;
    if (low !== 0) begin errors++; $display("FAIL wr_oen got %0d driven bits want 0", low); end
    run_frame(32, OP_READ, 5'h03, 5'd2, 16'h0, rd, low, t1, t2);
    checks++;
    if (rd !== 16'hBEEF) begin errors++; $display("FAIL rd_reg2 got %h want beef", rd); end
  endtask

  task automatic test_unimpl();
    logic [15:0] rd; int low; logic t1; logic [1:0] t2; int s0;
    s0 = strobe_cnt;
    run_frame(32, OP_WRITE, 5'h03, 5'd20, 16'hA5A5, rd, low, t1, t2);
    checks++;
    if (strobe_cnt - s0 !== 1 || bus.wr_regad !== 5'd20 || bus.wr_data !== 16'hA5A5) begin
      errors++; $display("FAIL unimpl_wr got %0d/%h/%h want 1/14/a5a5", strobe_cnt - s0, bus.wr_regad, bus.wr_data);
    end
    run_frame(32, OP_READ, 5'h03, 5'd20, 16'h0, rd, low, t1, t2);
    checks++;
    if (rd !== 16'h0000) begin errors++; $display("FAIL unimpl_rd got %h want 0000", rd); end
  endtask

  task automatic test_status();
    logic [15:0] rd; int low; logic t1; logic [1:0] t2;
    logic [15:0] exp0;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    exp0 = 16'h0040;
`else
    exp0 = 16'h0000;
`endif
    bus.status_in = 16'h796D;
    run_frame(32, OP_READ, 5'h03, REGAD_STATUS, 16'h0, rd, low, t1, t2);
    checks++;
    if (rd !== 16'h796D) begin errors++; $display("FAIL status_796d got %h want 796d", rd); end
    bus.status_in = 16'h0000;
    run_frame(32, OP_READ, 5'h03, REGAD_STATUS, 16'h0, rd, low, t1, t2);
    checks++;
    if (rd !== exp0) begin errors++; $display("FAIL status_zero got %h want %h", rd, exp0); end
  endtask

  task automatic test_skip();
    logic [15:0] rd; int low; logic t1; logic [1:0] t2; int s0; int exp_s;
    s0 = strobe_cnt;
    run_frame(32, OP_READ, 5'h04, 5'd0, 16'h0, rd, low, t1, t2);
    checks++;
    if (low !== 0 || strobe_cnt !== s0) begin
      errors++; $display("FAIL skip got %0d driven/%0d strobes want 0/0", low, strobe_cnt - s0);
    end
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    exp_s = 1;
`else
    exp_s = 0;
`endif
    // Only the trailing idle bit of the skipped frame precedes this one.
    run_frame(0, OP_WRITE, 5'h03, 5'd3, 16'h1234, rd, low, t1, t2);
    checks++;
    if (strobe_cnt - s0 !== exp_s) begin
      errors++; $display("FAIL no_preamble got %0d strobes want %0d", strobe_cnt - s0, exp_s);
    end
  endtask

  task automatic test_bad_op();
    logic [15:0] rd; int low; logic t1; logic [1:0] t2; int e0; int s0;
    logic so, sout;
    e0 = err_cnt; s0 = strobe_cnt;
    run_frame(32, 2'b11, 5'h03, 5'd2, 16'h0000, rd, low, t1, t2);
    checks++;
    if (err_cnt - e0 !== 1 || low !== 0) begin
      errors++; $display("FAIL bad_op got %0d errs/%0d driven want 1/0", err_cnt - e0, low);
    end
    bit_cycle(1'b0, so, sout);
    run_frame(31, OP_WRITE, 5'h03, 5'd4, 16'h5555, rd, low, t1, t2);
    checks++;
    if (strobe_cnt !== s0) begin errors++; $display("FAIL short_preamble got %0d strobes want 0", strobe_cnt - s0); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] fr; logic so, sout; int s0;
    s0 = strobe_cnt;
    fr = build_frame(OP_READ, 5'h03, 5'd2, 16'h0);
    for (int i = 0; i < 32; i++) bit_cycle(1'b1, so, sout);
    for (int i = 31; i > 8; i--) bit_cycle(fr[i], so, sout);
    // Bit D8: line should be driven, then reset arrives mid-bit.
    bus.mdio_in = 1'b1;
    #80;
    checks++;
    if (bus.mdio_oen !== 1'b0) begin errors++; $display("FAIL d8_driven got oen %b want 0", bus.mdio_oen); end
    bus.mdc = 1'b1;
    #43 reset_reset = 1'b1;
    #4;
    checks++;
    if (bus.mdio_oen !== 1'b1 || bus.mdio_out !== 1'b1 || bus.state !== IDLE) begin
      errors++; $display("FAIL mid_reset got oen %b out %b state %0d want 1 1 IDLE", bus.mdio_oen, bus.mdio_out, bus.state);
    end
    #20 reset_reset = 1'b0;
    #13 bus.mdc = 1'b0;
    checks++;
    if (strobe_cnt !== s0) begin errors++; $display("FAIL mid_reset_strobe got %0d want 0", strobe_cnt - s0); end
    test_read_reg0("post_reset");
  endtask

  initial begin
    test_reset();
    @(negedge clk_clk);
    test_read_reg0("rd_reg0");
    test_write_read();
    test_unimpl();
    test_status();
    test_skip();
    test_bad_op();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
